jp_responder: RTL and testbench

- Emulates two standard NES controllers (4021-style parallel-in/serial-out) on the joypad wire protocol that the rp2a03 joypad controller drives.
- Responds to that controller's jp_clk/jp_latch strobes.
- Sits between the PS/2 keyboard-to-button mapping and the rp2a03 jp_data1_in/jp_data2_in pins.
- Supplies button snapshots bit-serially and reports completed reads.

---
 rtl/nes_pkg.sv | 26 ++
 rtl/jp_sync_edge.sv | 36 +++
 rtl/jp_responder.sv | 142 ++++++++++++++
 tb/tb_jp_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES joypad definitions: button bit positions, serial frame length
// and the responder state encoding.
package nes_pkg;

    // Button bit positions within an 8-bit pad snapshot (1 = pressed)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Number of button bits shifted out per read
    localparam int JP_BITS = 8;

    // Responder state, shared by both emulated pads
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } jp_state_e;

endpackage

// File: rtl/jp_sync_edge.sv
// N-stage synchronizer for an asynchronous strobe, followed by one edge
// register that turns the synchronized level into rise/fall pulses.
module jp_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;
    logic              level;

    // Synchronizer chain; left free-running through reset so a pin that is
    // already high is seen as a rising edge right after reset releases.
    always_ff @(posedge clk) begin
        sync <= {sync[STAGES-2:0], d};
    end

    // Edge register; clears on reset so a held-high pin re-triggers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/jp_responder.sv
// Emulates two 4021-style NES pads on the joypad latch/clock wire protocol.
// Handshake-free: the controller owns jp_clk/jp_latch, this block only reacts
// to their synchronized edges and presents one data bit per pad.
module jp_responder
    import nes_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit DATA_INV    = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       jp_clk_in,
    input  logic       jp_latch_in,
    input  logic [7:0] btn1_in,
    input  logic [7:0] btn2_in,
    output logic       jp_data1_out,
    output logic       jp_data2_out,
    output logic       read_done_out,
    output logic       partial_out
);

    jp_state_e  state;
    jp_state_e  state_next;
    logic [7:0] sh1;
    logic [7:0] sh2;
    logic [3:0] cnt;
    logic       load;
    logic       shift;
    logic       finish;
    logic       set_partial;
    logic       read_done;
    logic       partial;
    logic       clk_rise;
    logic       clk_fall_unused;
    logic       latch_rise;
    logic       latch_fall;

    jp_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk  (clk_in),
        .rst  (rst_in),
        .d    (jp_clk_in),
        .rise (clk_rise),
        .fall (clk_fall_unused)
    );

    jp_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk  (clk_in),
        .rst  (rst_in),
        .d    (jp_latch_in),
        .rise (latch_rise),
        .fall (latch_fall)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes; a latch edge always beats a clock edge
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        shift       = 1'b0;
        finish      = 1'b0;
        set_partial = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (latch_rise) begin
                    state_next = ST_LOAD;
                    load       = 1'b1;
                end
            end
            ST_LOAD: begin
                // Parallel load every cycle, including the falling-edge cycle
                // whose buttons become the held snapshot.
                load = 1'b1;
                if (latch_fall) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (latch_rise) begin
                    state_next  = ST_LOAD;
                    load        = 1'b1;
                    set_partial = (cnt != 4'd0);
                end else if (clk_rise) begin
                    shift = 1'b1;
                    if (cnt == 4'(JP_BITS - 1)) begin
                        finish     = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (latch_rise) begin
                    state_next = ST_LOAD;
                    load       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-pad shift registers and shared bit counter; 1s fill from the top
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sh1 <= 8'h00;
            sh2 <= 8'h00;
            cnt <= 4'd0;
        end else if (load) begin
            sh1 <= btn1_in;
            sh2 <= btn2_in;
            cnt <= 4'd0;
        end else if (shift) begin
            sh1 <= {1'b1, sh1[7:1]};
            sh2 <= {1'b1, sh2[7:1]};
            cnt <= cnt + 4'd1;
        end
    end

    // Completion pulse and sticky short-read flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            read_done <= 1'b0;
            partial   <= 1'b0;
        end else begin
            read_done <= finish;
            partial   <= partial | set_partial;
        end
    end

    // After the last button bit a real pad reports "pressed"
    assign jp_data1_out  = ((cnt == 4'(JP_BITS)) ? 1'b1 : sh1[BTN_A]) ^ DATA_INV;
    assign jp_data2_out  = ((cnt == 4'(JP_BITS)) ? 1'b1 : sh2[BTN_A]) ^ DATA_INV;
    assign read_done_out = read_done;
    assign partial_out   = partial;

endmodule

// File: tb/tb_jp_responder.sv
// Directed plus randomized bench for jp_responder, checked against a
// read-level model of the pad protocol (snapshot + bit index).
module tb_jp_responder;

    localparam bit INV = 1'b1;

    logic       clk_in      = 1'b0;
    logic       rst_in      = 1'b1;
    logic       jp_clk_in   = 1'b0;
    logic       jp_latch_in = 1'b0;
    logic [7:0] btn1_in     = 8'h00;
    logic [7:0] btn2_in     = 8'h00;
    logic       jp_data1_out;
    logic       jp_data2_out;
    logic       read_done_out;
    logic       partial_out;

    // clock
    always #5 clk_in = ~clk_in;

    jp_responder #(.SYNC_STAGES(2), .DATA_INV(INV)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .jp_clk_in     (jp_clk_in),
        .jp_latch_in   (jp_latch_in),
        .btn1_in       (btn1_in),
        .btn2_in       (btn2_in),
        .jp_data1_out  (jp_data1_out),
        .jp_data2_out  (jp_data2_out),
        .read_done_out (read_done_out),
        .partial_out   (partial_out)
    );

    int n_checks  = 0;
    int n_fails   = 0;
    int done_seen = 0;

    // model of one pad read
    logic [7:0] snap1 = 8'h00;
    logic [7:0] snap2 = 8'h00;
    int         idx       = 0;
    bit         reading   = 1'b0;
    bit         latch_hi  = 1'b0;
    bit         m_partial = 1'b0;
    int         exp_done  = 0;

    // count completion pulses
    always @(negedge clk_in) begin
        if (!rst_in && read_done_out === 1'b1) done_seen++;
    end

    // watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_bit(input logic [7:0] live, input logic [7:0] snap);
        if (latch_hi) return live[0];
        if (!reading) return 1'b0;
        if (idx >= 8) return 1'b1;
        return snap[idx];
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        @(negedge clk_in);
        check({tag, "_d1"},      {7'd0, jp_data1_out}, {7'd0, model_bit(btn1_in, snap1) ^ INV});
        check({tag, "_d2"},      {7'd0, jp_data2_out}, {7'd0, model_bit(btn2_in, snap2) ^ INV});
        check({tag, "_partial"}, {7'd0, partial_out},  {7'd0, m_partial});
        check({tag, "_donecnt"}, 8'(done_seen),        8'(exp_done));
    endtask

    task automatic latch_pulse(input logic [7:0] b1, input logic [7:0] b2);
        @(posedge clk_in);
        #1;
        btn1_in     = b1;
        btn2_in     = b2;
        jp_latch_in = 1'b1;
        if (reading && idx >= 1 && idx <= 7) m_partial = 1'b1;
        reading  = 1'b0;
        latch_hi = 1'b1;
        wait_cyc($urandom_range(5, 7));
        check_outputs("latch_hi");
        jp_latch_in = 1'b0;
        latch_hi    = 1'b0;
        reading     = 1'b1;
        idx         = 0;
        snap1       = btn1_in;
        snap2       = btn2_in;
        wait_cyc($urandom_range(5, 7));
        check_outputs("latch_lo");
    endtask

    task automatic clk_pulse(input string tag);
        logic [3:0] v;
        logic [3:0] exp_v;
        @(posedge clk_in);
        #1;
        jp_clk_in = 1'b1;
        exp_v = 4'b0000;
        if (reading && !latch_hi && idx < 8) begin
            idx++;
            if (idx == 8) begin
                exp_v = 4'b1000;
                exp_done++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            v[i] = read_done_out;
        end
        check({tag, "_done_timing"}, {4'd0, v}, {4'd0, exp_v});
        wait_cyc($urandom_range(2, 4));
        jp_clk_in = 1'b0;
        wait_cyc($urandom_range(4, 6));
        check_outputs(tag);
    endtask

    task automatic reset_pulse();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in    = 1'b0;
        reading   = 1'b0;
        idx       = 0;
        m_partial = 1'b0;
        snap1     = 8'h00;
        snap2     = 8'h00;
        check_outputs("reset_mid");
    endtask

    initial begin
        // reset
        wait_cyc(5);
        rst_in = 1'b0;
        check_outputs("reset_state");

        // A+Start on pad 1, Right on pad 2, read 10 bits
        latch_pulse(8'h09, 8'h80);
        for (int i = 0; i < 10; i++) clk_pulse($sformatf("t1_clk%0d", i + 1));

        // latch held high, pad 1 toggles A; output follows live
        @(posedge clk_in);
        #1;
        jp_latch_in = 1'b1;
        latch_hi    = 1'b1;
        reading     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn1_in = (i % 2 == 0) ? 8'h01 : 8'h00;
            btn2_in = 8'($urandom_range(0, 255));
            wait_cyc(5);
            check_outputs($sformatf("live_%0d", i));
        end
        btn1_in     = 8'h01;
        wait_cyc(5);
        jp_latch_in = 1'b0;
        latch_hi    = 1'b0;
        reading     = 1'b1;
        idx         = 0;
        snap1       = btn1_in;
        snap2       = btn2_in;
        wait_cyc(6);
        btn1_in = 8'hFE;
        btn2_in = ~btn2_in;
        check_outputs("held_snap");
        for (int i = 0; i < 8; i++) clk_pulse($sformatf("t3_clk%0d", i + 1));

        // short read then full read
        latch_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) clk_pulse("t4_short");
        latch_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) clk_pulse("t4_full");

        // latch and clock rise together
        latch_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 2; i++) clk_pulse("t5_pre");
        @(posedge clk_in);
        #1;
        btn1_in     = 8'($urandom_range(0, 255));
        btn2_in     = 8'($urandom_range(0, 255));
        jp_latch_in = 1'b1;
        jp_clk_in   = 1'b1;
        m_partial   = 1'b1;
        reading     = 1'b0;
        latch_hi    = 1'b1;
        wait_cyc(6);
        check_outputs("same_edge_hi");
        jp_latch_in = 1'b0;
        jp_clk_in   = 1'b0;
        latch_hi    = 1'b0;
        reading     = 1'b1;
        idx         = 0;
        snap1       = btn1_in;
        snap2       = btn2_in;
        wait_cyc(6);
        check_outputs("same_edge_lo");
        for (int i = 0; i < 8; i++) clk_pulse("t5_read");

        // reset mid-read, then a clean read
        latch_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) clk_pulse("t6_pre");
        reset_pulse();
        latch_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) clk_pulse("t6_read");

        // random reads of random length
        for (int r = 0; r < 6; r++) begin
            int n;
            latch_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) clk_pulse($sformatf("rnd%0d", r));
        end

        wait_cyc(6);
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
